// File: rtl/uart_msg_responder.sv
// Command/response debug responder: a UART command byte selects a ROM message that is streamed to the
// UART transmitter one byte per tx_start/tx_done handshake. Optional feature macro: MSG_CRLF_EN (appends CR LF).
module uart_msg_responder #(
   parameter int                                ADDR_W         = 4,
   parameter int                                NUM_MSG        = 4,
   parameter logic [8*(2**ADDR_W)-1:0]          ROM_INIT       = "sabroXERR?",
   parameter logic [ADDR_W*NUM_MSG-1:0]         MSG_START      = 16'h6520,
   parameter logic [ADDR_W*NUM_MSG-1:0]         MSG_LEN        = 16'h4132,
   parameter int                                GAP_CYCLES     = 8,
   parameter int                                TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       cmd_err,
   output logic       tx_timeout
);

   // Handshake: tx_start is a one-cycle pulse in SEND with tx_data valid; tx_data holds through WAIT
   // until the single-cycle tx_done. rx_done is a single-cycle strobe honoured only in IDLE.

   localparam int ROM_DEPTH = 2**ADDR_W;

   // ROM_INIT is read in string order: its first character lands at address 0.
   function automatic logic [8*ROM_DEPTH-1:0] build_rom(input logic [8*ROM_DEPTH-1:0] init);
      logic [8*ROM_DEPTH-1:0] rom;
      int n;
      rom = '0;
      n   = 0;
      for (int i = 0; i < ROM_DEPTH; i++)
         if (init[8*i +: 8] != 8'h00) n = i + 1;
      for (int i = 0; i < ROM_DEPTH; i++)
         if (i < n) rom[8*i +: 8] = init[8*(n-1-i) +: 8];
      return rom;
   endfunction

   localparam logic [8*ROM_DEPTH-1:0] ROM = build_rom(ROM_INIT);

   function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < ROM_DEPTH; i++)
         if (a == ADDR_W'(i)) b = ROM[8*i +: 8];
      return b;
   endfunction

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
      WAIT = 3'd3,
      GAP  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   off_q, off_d;
   logic [31:0]         cnt_q, cnt_d;
`ifdef MSG_CRLF_EN
   logic [1:0]          phase_q, phase_d;
`endif

   logic [ADDR_W-1:0]   msg_start;
   logic [ADDR_W-1:0]   msg_len;
   logic                cmd_bad;
   logic [ADDR_W-1:0]   addr;

   // Command decode: 1..NUM_MSG-1 pick message cmd-1, everything else the error message.
   always_comb begin
      msg_start = MSG_START[ADDR_W*(NUM_MSG-1) +: ADDR_W];
      msg_len   = MSG_LEN[ADDR_W*(NUM_MSG-1) +: ADDR_W];
      cmd_bad   = 1'b1;
      for (int k = 0; k < NUM_MSG-1; k++) begin
         if (cmd_q == 8'(k+1)) begin
            msg_start = MSG_START[ADDR_W*k +: ADDR_W];
            msg_len   = MSG_LEN[ADDR_W*k +: ADDR_W];
            cmd_bad   = 1'b0;
         end
      end
   end

   assign addr = msg_start + off_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cmd_q   <= 8'h00;
         off_q   <= '0;
         cnt_q   <= '0;
`ifdef MSG_CRLF_EN
         phase_q <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
`ifdef MSG_CRLF_EN
         phase_q <= phase_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      off_d      = off_q;
      cnt_d      = cnt_q;
`ifdef MSG_CRLF_EN
      phase_d    = phase_q;
`endif
      tx_start   = 1'b0;
      cmd_err    = 1'b0;
      tx_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_done && rx_data != 8'h00) begin
               cmd_d   = rx_data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cmd_err = cmd_bad;
            off_d   = '0;
            cnt_d   = '0;
`ifdef MSG_CRLF_EN
            phase_d = 2'd0;
`endif
            state_d = (msg_len == '0) ? IDLE : SEND;
         end
         SEND: begin
            tx_start = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            // tx_done wins over a timeout expiring in the same cycle.
            if (tx_done) begin
               cnt_d   = '0;
               state_d = (GAP_CYCLES > 0) ? GAP : SEND;
`ifdef MSG_CRLF_EN
               if (phase_q == 2'd2) begin
                  state_d = IDLE;
               end else if (phase_q == 2'd1) begin
                  phase_d = 2'd2;
               end else if (off_q == msg_len - 1'b1) begin
                  phase_d = 2'd1;
               end else begin
                  off_d = off_q + 1'b1;
               end
`else
               if (off_q == msg_len - 1'b1) state_d = IDLE;
               else                         off_d   = off_q + 1'b1;
`endif
            end else if (TIMEOUT_CYCLES > 0 && cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
               tx_timeout = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q >= 32'(GAP_CYCLES - 1)) state_d = SEND;
            else                              cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_data = 8'h00;
      if (state_q == SEND || state_q == WAIT) begin
`ifdef MSG_CRLF_EN
         case (phase_q)
            2'd1:    tx_data = 8'h0D;
            2'd2:    tx_data = 8'h0A;
            default: tx_data = rom_byte(addr);
         endcase
`else
         tx_data = rom_byte(addr);
`endif
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_msg_responder.sv
// Directed bench for uart_msg_responder: drives command bytes and answers the tx handshake,
// checking bytes, latencies, gaps, error/timeout pulses, dropped commands and async reset.
module tb_uart_msg_responder;

   localparam int GAP = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_done;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       cmd_err;
   logic       tx_timeout;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   uart_msg_responder dut (
      .clk        (clk),
      .reset      (reset),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy),
      .cmd_err    (cmd_err),
      .tx_timeout (tx_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_crlf();
`ifdef MSG_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
   endtask

   // Leaves the bench in the LOAD cycle (one cycle after the rx_done cycle).
   task automatic send_cmd(input logic [7:0] cmd);
      rx_data = cmd;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int exp_wait, output bit ok);
      int waited;
      waited = 0;
      while (tx_start !== 1'b1 && waited < 40) begin
         step();
         waited++;
      end
      ok = (tx_start === 1'b1);
      if (!ok) check({tag, "_missing"}, 32'(tx_start), 32'd1);
      else     check(tag, 32'(waited), 32'(exp_wait));
   endtask

   // Serves every byte in exp_q with tx_done dly cycles after tx_start; optional dropped commands.
   task automatic serve(input int dly, input bit inject);
      bit ok;
      bit first;
      logic [7:0] exp_b;
      first = 1'b1;
      while (exp_q.size() > 0) begin
         if (first) wait_start("first_latency", 1, ok);
         else       wait_start("gap_latency", GAP, ok);
         if (!ok) begin
            exp_q.delete();
            return;
         end
         exp_b = exp_q.pop_front();
         check("tx_data", 32'(tx_data), 32'(exp_b));
         check("busy_in_msg", 32'(busy), 32'd1);
         step();
         check("tx_start_pulse", 32'(tx_start), 32'd0);
         if (inject && first) begin
            rx_data = 8'h03;
            rx_done = 1'b1;
         end
         for (int i = 1; i < dly; i++) begin
            step();
            rx_done = 1'b0;
         end
         check("tx_data_stable", 32'(tx_data), 32'(exp_b));
         tx_done = 1'b1;
         if (inject && exp_q.size() == 0) begin
            rx_data = 8'h01;
            rx_done = 1'b1;
         end
         step();
         tx_done = 1'b0;
         rx_done = 1'b0;
         first   = 1'b0;
      end
      check("busy_after_msg", 32'(busy), 32'd0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int starts;
      starts = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (tx_start === 1'b1) starts++;
      end
      check({tag, "_no_tx"}, 32'(starts), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit ok;
      int k;
      reset   = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      tx_done = 1'b0;

      // 1: commands under reset are ignored
      for (int i = 0; i < 4; i++) begin
         rx_data = 8'h02;
         rx_done = ~rx_done;
         step();
         check("reset_outputs", {28'd0, tx_start, cmd_err, busy, tx_timeout}, 32'd0);
      end
      rx_done = 1'b0;
      reset   = 1'b0;
      quiet("post_reset", 20);

      // 2: cmd 2 -> "bro"
      send_cmd(8'h02);
      check("cmd2_no_err", 32'(cmd_err), 32'd0);
      exp_q.push_back(8'h62);
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h6F);
      push_crlf();
      serve(3, 1'b0);

      // 3: unknown command -> error message; cmd 0 is a no-op
      send_cmd(8'h41);
      check("cmd41_err", 32'(cmd_err), 32'd1);
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h3F);
      push_crlf();
      serve(3, 1'b0);
      send_cmd(8'h00);
      check("cmd0_idle", 32'(busy), 32'd0);
      quiet("cmd0", 10);

      // 4: no tx_done -> timeout 1024 cycles after tx_start, then a normal command
      send_cmd(8'h01);
      wait_start("tmo_first_latency", 1, ok);
      check("tmo_first_byte", 32'(tx_data), 32'h73);
      k = 0;
      do begin
         step();
         k++;
      end while (tx_timeout !== 1'b1 && k < 1100);
      check("timeout_cycles", 32'(k), 32'd1024);
      step();
      check("tmo_idle", 32'(busy), 32'd0);
      check("tmo_pulse_end", 32'(tx_timeout), 32'd0);
      send_cmd(8'h01);
      exp_q.push_back(8'h73);
      exp_q.push_back(8'h61);
      push_crlf();
      serve(3, 1'b0);

      // 5: commands mid-message and on the last tx_done are dropped
      send_cmd(8'h02);
      exp_q.push_back(8'h62);
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h6F);
      push_crlf();
      serve(3, 1'b1);
      quiet("dropped_cmds", 30);

`ifdef MSG_CRLF_EN
      // 6: cmd 3 -> "X" CR LF
      send_cmd(8'h03);
      exp_q.push_back(8'h58);
      push_crlf();
      serve(3, 1'b0);
      send_cmd(8'h03);
`else
      send_cmd(8'h02);
`endif
      // Async reset in the WAIT of the second byte clears outputs without a clock edge
      wait_start("rst_first_latency", 1, ok);
      step();
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      wait_start("rst_second_latency", GAP, ok);
`ifdef MSG_CRLF_EN
      check("rst_second_byte", 32'(tx_data), 32'h0D);
`else
      check("rst_second_byte", 32'(tx_data), 32'h72);
`endif
      step();
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", {19'd0, tx_start, cmd_err, busy, tx_timeout, tx_data}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      quiet("after_async_reset", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
